// File: rtl/inst_fetch_resp_pkg.sv
// Shared fetch-interface definitions: bus widths, the NOP word, the default
// bus timeout and the responder FSM state encoding.
package inst_fetch_resp_pkg;

   localparam int INST_ADDR_BUS = 32;
   localparam int INST_BUS      = 32;
   localparam int FETCH_TIMEOUT = 16;

   localparam logic [INST_BUS-1:0] NOP_INST = 32'h0;

   typedef enum logic [0:0] {
      FETCH_IDLE = 1'b0,
      FETCH_WAIT = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/inst_fetch_resp_fetch_buf.sv
// One-entry instruction buffer: a single tagged word with an error flag,
// written by the bus side and looked up combinationally by the fetch side.
module fetch_buf
   import inst_fetch_resp_pkg::*;
#(
   parameter int ADDR_W = INST_ADDR_BUS,
   parameter int DATA_W = INST_BUS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_tag,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_err,
   input  logic [ADDR_W-1:0] lookup_tag,
   output logic              hit,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_err
);

   logic              buf_valid;
   logic [ADDR_W-1:0] buf_tag;
   logic [DATA_W-1:0] buf_data;
   logic              buf_err;

   // NOTE: the data word is reset along with valid so an empty buffer reads as
   // a NOP instead of X; it is a single register, not a RAM array.
   // NOTE: sequential state uses <= so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst) begin
         buf_valid <= 1'b0;
         buf_tag   <= '0;
         buf_data  <= DATA_W'(NOP_INST);
         buf_err   <= 1'b0;
      end else if (wr_en) begin
         buf_valid <= 1'b1;
         buf_tag   <= wr_tag;
         buf_data  <= wr_data;
         buf_err   <= wr_err;
      end
   end

   assign hit     = buf_valid && (buf_tag == lookup_tag);
   assign rd_data = buf_data;
   assign rd_err  = buf_err;

endmodule

// File: rtl/inst_fetch_resp.sv
// Instruction-fetch responder: serves the fetch stage from a one-entry buffer
// and refills it over a req/ack memory bus, stalling the pipeline until ready.
module inst_fetch_resp
   import inst_fetch_resp_pkg::*;
#(
   parameter int ADDR_W  = INST_ADDR_BUS,
   parameter int DATA_W  = INST_BUS,
   parameter int TIMEOUT = FETCH_TIMEOUT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [ADDR_W-1:0] addr,
   output logic [DATA_W-1:0] inst,
   output logic              inst_err,
   output logic              stallreq,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int TIMER_W = $clog2(TIMEOUT) + 1;

   fetch_state_t        state;
   fetch_state_t        next_state;
   logic [TIMER_W-1:0]  timer;

   logic                aligned;
   logic                hit;
   logic                miss;
   logic                timed_out;
   logic                fill;
   logic [DATA_W-1:0]   fill_data;
   logic [DATA_W-1:0]   buf_data;
   logic                buf_err;

   assign aligned   = (addr[1:0] == 2'b00);
   assign miss      = ce && aligned && !hit;
   assign timed_out = (timer == TIMER_W'(TIMEOUT - 1));

   fetch_buf #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_buf (
      .clk        (clk),
      .rst        (rst),
      .wr_en      (fill),
      .wr_tag     (mem_addr),
      .wr_data    (fill_data),
      .wr_err     (!mem_ack),
      .lookup_tag (addr),
      .hit        (hit),
      .rd_data    (buf_data),
      .rd_err     (buf_err)
   );

   // State register plus the transaction address and timeout timer.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= FETCH_IDLE;
         mem_addr <= '0;
         timer    <= '0;
      end else begin
         state <= next_state;
         if (state == FETCH_IDLE && miss) begin
            mem_addr <= {addr[ADDR_W-1:2], 2'b00};
            timer    <= '0;
         end else if (state == FETCH_WAIT && !mem_ack && !timed_out) begin
            timer <= timer + TIMER_W'(1);
         end
      end
   end

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      next_state = state;
      case (state)
         FETCH_IDLE: if (miss) next_state = FETCH_WAIT;
         FETCH_WAIT: if (mem_ack || timed_out) next_state = FETCH_IDLE;
         default:    next_state = FETCH_IDLE;
      endcase
   end

   // Ack wins over a timeout landing in the same cycle.
   always_comb begin
      mem_req   = (state == FETCH_WAIT);
      fill      = (state == FETCH_WAIT) && (mem_ack || timed_out);
      fill_data = mem_ack ? mem_rdata : DATA_W'(NOP_INST);
      inst      = DATA_W'(NOP_INST);
      inst_err  = 1'b0;
      stallreq  = 1'b0;
      if (rst && ce) begin
         if (!aligned) begin
            inst_err = 1'b1;
         end else if (hit) begin
            inst     = buf_data;
            inst_err = buf_err;
         end else begin
            stallreq = 1'b1;
         end
      end
   end

endmodule

// File: doc/inst_fetch_resp.md
Name: inst_fetch_resp

Overview:
Responder end of the instruction-fetch interface. Accepts the PC/chip-enable request from the fetch stage and returns the instruction word. Sources words from an external ready/ack memory bus and holds the last fetched word in a one-entry buffer. Raises a stall request to the pipeline controller until the word for the current PC is available.

Parameters:
ADDR_W, 32, fetch address width (matches InstAddrBus)
DATA_W, 32, instruction width (matches InstBus)
TIMEOUT, 16, max cycles waiting for mem_ack before abort (must be >= 1)

Ports:
clk  in  1  clock, all state updates on posedge
rst  in  1  synchronous, active-low reset (rst==0 resets on the clock edge)
ce  in  1  fetch request enable from the fetch stage
addr  in  ADDR_W  fetch address (PC)
inst  out  DATA_W  instruction for the current addr
inst_err  out  1  inst is a substituted NOP due to misalignment or bus timeout
stallreq  out  1  stall request to the pipeline controller
mem_req  out  1  memory bus request
mem_addr  out  ADDR_W  word-aligned memory address
mem_ack  in  1  memory bus acknowledge; mem_rdata valid this cycle
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst==0 at posedge): state IDLE, buf_valid=0, buf_tag=0, buf_data=0, buf_err=0, mem_req=0, mem_addr=0, timer=0. Outputs while rst==0: inst=0, inst_err=0, stallreq=0.
- hit = buf_valid && (buf_tag == addr). This is combinational on the current addr.
- ce==0: inst=0 (NOP), inst_err=0, stallreq=0. No new request is issued. An in-flight transaction still completes (see below).
- Misaligned (ce==1, addr[1:0]!=0): inst=0, inst_err=1, stallreq=0. No request is issued. Takes precedence over hit/miss.
- ce==1 && aligned && hit: inst=buf_data, inst_err=buf_err, stallreq=0. Same cycle, combinational.
- ce==1 && aligned && !hit: inst=0, stallreq=1.
- FSM states:
  - IDLE: on a miss with ce==1 and aligned, register mem_req=1 and mem_addr=addr, clear timer, go to WAIT.
  - WAIT: mem_req held at 1 and mem_addr held stable until mem_ack or timeout. A request is never retracted early.
    - On mem_ack: buf_tag=mem_addr, buf_data=mem_rdata, buf_err=0, buf_valid=1, mem_req=0, go to IDLE.
    - If timer reaches TIMEOUT-1 without mem_ack: buf_tag=mem_addr, buf_data=0, buf_err=1, buf_valid=1, mem_req=0, go to IDLE.
    - Otherwise timer increments by 1. timer width is clog2(TIMEOUT)+1 and it never wraps.
- Miss latency: request registers on edge N; earliest mem_ack is in cycle N+1. The buffer fills on that edge and hit is true in cycle N+2. A miss therefore costs at least 2 stall cycles.
- addr changes during WAIT (branch redirect): the outstanding transaction completes and fills the buffer with the old tag. The next cycle is a miss for the new addr and a new request is issued. No data for the wrong address is ever presented without stallreq=0 and a matching tag.
- Back-to-back: a new request can be issued in the cycle immediately after returning to IDLE. No dead cycle is required beyond the FSM transition.
- mem_ack while in IDLE is ignored (protocol error, no state change).
- Reset asserted mid-WAIT: mem_req drops on that edge and the buffer is invalidated. The memory side is required to tolerate request abandonment on reset.

Decomposition:
- Shared defines file gains: InstAddrBus/InstBus reuse, a FETCH_IDLE/FETCH_WAIT state encoding, NopInst (32'h0), and a FetchTimeout default.
- The one-entry buffer (tag/data/err/valid plus hit compare) is a natural sub-module, fetch_buf, with write port and combinational lookup.
- FSM and timer stay in the top module.

Test Plan:
- Reset: rst=0 for 2 cycles with ce=1, addr=0 -> inst=0, stallreq=0, mem_req=0. Release with addr=0 -> mem_req=1, mem_addr=0 on the next edge.
- Miss then hit: addr=0x100, memory acks 2 cycles after req with 0x24010005 -> stallreq high for 3 cycles, then inst=0x24010005, stallreq=0, inst_err=0. The next cycle at the same addr issues no new mem_req.
- Sequential stream: addr steps 0x0, 0x4, 0x8 with zero-wait memory (ack in the cycle after req) -> each word is delivered after exactly 2 stall cycles. mem_addr sequence is 0x0, 0x4, 0x8 with no duplicates.
- Redirect mid-WAIT: request 0x200 pending, addr switches to 0x400 before ack -> ack for 0x200 is absorbed, then mem_req for 0x400. inst is never 0x200's data while stallreq=0.
- Timeout: TIMEOUT=4, memory never acks -> mem_req high for exactly 4 cycles, then drops. Next cycle inst=0, inst_err=1, stallreq=0 at that addr.
- Misaligned and ce=0: addr=0x102 -> inst_err=1, stallreq=0, no mem_req. ce=0 during WAIT -> stallreq=0, inst=0, and the transaction still completes on mem_ack.
